// File: rtl/sdr_upload_reader.sv
// rtl/sdr_upload_reader.sv - HPS upload byte reader over an SDRAM window
// One-word cache in front of SDRAM ch3; misses fetch a 16-bit word, out-of-range reads return 8'hFF.
module sdr_upload_reader #(
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter logic [23:0] BASE_ADDR    = 24'h0,
  parameter logic [24:0] SIZE_BYTES   = 25'd1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        save_trigger,
  output logic        ioctl_upload_req,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        sdr_active,
  output logic [24:1] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_rdy,
  input  logic [15:0] sdr_dout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]  state;
  logic        active_d;
  logic        cache_valid;
  logic [23:0] cache_tag;
  logic [15:0] cache_word;
  logic [23:0] pend_tag;
  logic        pend_byte;

  logic        active;
  logic        active_rise;
  logic        in_range;
  logic        hit;
  logic [7:0]  cache_byte;
  logic [7:0]  fetch_byte;

  assign active      = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign active_rise = active && !active_d;
  assign in_range    = ioctl_addr < SIZE_BYTES;
  // A new upload starting this very edge must not hit on a stale word.
  assign hit         = cache_valid && !active_rise && (cache_tag == ioctl_addr[24:1]);
  assign cache_byte  = ioctl_addr[0] ? cache_word[15:8] : cache_word[7:0];
  assign fetch_byte  = pend_byte ? sdr_dout[15:8] : sdr_dout[7:0];

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= ST_IDLE;
      active_d         <= 1'b0;
      cache_valid      <= 1'b0;
      cache_tag        <= 24'h0;
      cache_word       <= 16'h0;
      pend_tag         <= 24'h0;
      pend_byte        <= 1'b0;
      ioctl_upload_req <= 1'b0;
      ioctl_din        <= 8'h00;
      ioctl_wait       <= 1'b0;
      sdr_active       <= 1'b0;
      sdr_addr         <= BASE_ADDR;
      sdr_req          <= 1'b0;
    end else begin
      active_d         <= active;
      ioctl_upload_req <= save_trigger;
      case (state)
        ST_IDLE: begin
          sdr_active <= 1'b0;
          if (ioctl_rd && active) begin
            if (!in_range) begin
              ioctl_din <= 8'hFF;
            end else if (hit) begin
              ioctl_din <= cache_byte;
            end else begin
              pend_tag   <= ioctl_addr[24:1];
              pend_byte  <= ioctl_addr[0];
              sdr_addr   <= BASE_ADDR + ioctl_addr[24:1];
              sdr_req    <= 1'b1;
              ioctl_wait <= 1'b1;
              sdr_active <= 1'b1;
              state      <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (!active) begin
            // Upload aborted: release HPS now, but the SDRAM access must still complete.
            ioctl_wait <= 1'b0;
            if (sdr_rdy) begin
              sdr_req <= 1'b0;
              state   <= ST_IDLE;
            end else begin
              state   <= ST_DRAIN;
            end
          end else if (sdr_rdy) begin
            cache_word  <= sdr_dout;
            cache_tag   <= pend_tag;
            cache_valid <= 1'b1;
            ioctl_din   <= fetch_byte;
            sdr_req     <= 1'b0;
            ioctl_wait  <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (sdr_rdy) begin
            sdr_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          sdr_req    <= 1'b0;
          ioctl_wait <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
      if (active_rise) begin
        cache_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdr_upload_reader.sv
// tb/tb_sdr_upload_reader.sv - directed self-checking bench for sdr_upload_reader
// Small SDRAM responder model plus per-scenario tasks with hand-computed expectations.
module tb_sdr_upload_reader;

  localparam logic [7:0]  IDX  = 8'd4;
  localparam logic [23:0] BASE = 24'h000100;
  localparam logic [24:0] SIZE = 25'd16;

  logic        clk_sys;
  logic        reset;
  logic        save_trigger;
  logic        ioctl_upload_req;
  logic        ioctl_upload;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        sdr_active;
  logic [24:1] sdr_addr;
  logic        sdr_req;
  logic        sdr_rdy;
  logic [15:0] sdr_dout;

  int checks = 0;
  int passes = 0;

  logic [15:0] mem [0:7];
  int          rdy_lat = 3;
  logic        resp_en = 1'b1;
  int          req_cnt = 0;
  logic        req_q = 1'b0;
  logic [23:0] addr_log [$];

  sdr_upload_reader #(
    .UPLOAD_INDEX(IDX),
    .BASE_ADDR(BASE),
    .SIZE_BYTES(SIZE)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .save_trigger(save_trigger),
    .ioctl_upload_req(ioctl_upload_req),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_addr(ioctl_addr),
    .ioctl_rd(ioctl_rd),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .sdr_active(sdr_active),
    .sdr_addr(sdr_addr),
    .sdr_req(sdr_req),
    .sdr_rdy(sdr_rdy),
    .sdr_dout(sdr_dout)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    req_q <= sdr_req;
    if (sdr_req && !req_q) begin
      req_cnt <= req_cnt + 1;
      addr_log.push_back(sdr_addr);
    end
  end

  // SDRAM responder: pulses sdr_rdy rdy_lat cycles after seeing a request.
  initial begin
    logic [23:0] off;
    sdr_rdy  = 1'b0;
    sdr_dout = 16'h0;
    forever begin
      @(posedge clk_sys); #1;
      if (resp_en) sdr_rdy = 1'b0;
      if (sdr_req && resp_en) begin
        repeat (rdy_lat) @(posedge clk_sys);
        #1;
        if (sdr_req && resp_en) begin
          off      = sdr_addr - BASE;
          sdr_dout = mem[off[2:0]];
          sdr_rdy  = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_sys); #1;
  endtask

  task automatic do_read(input logic [24:0] a);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    tick();
    ioctl_rd   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (ioctl_wait && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      checks++;
      $display("FAIL %s timeout: ioctl_wait still %b after %0d cycles, need 0", name, ioctl_wait, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (ioctl_din !== 8'h00) $display("FAIL rst_din got %h exp 00", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL rst_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b0) $display("FAIL rst_req got %b exp 0", sdr_req); else passes++;
    checks++; if (sdr_active !== 1'b0) $display("FAIL rst_active got %b exp 0", sdr_active); else passes++;
    checks++; if (ioctl_upload_req !== 1'b0) $display("FAIL rst_upreq got %b exp 0", ioctl_upload_req); else passes++;
    checks++; if (sdr_addr !== BASE) $display("FAIL rst_addr got %h exp %h", sdr_addr, BASE); else passes++;
  endtask

  task automatic test_cached_read();
    int c0;
    ioctl_upload = 1'b1;
    ioctl_index  = IDX;
    tick(); tick();
    do_read(25'd0);
    checks++; if (ioctl_wait !== 1'b1) $display("FAIL miss_wait got %b exp 1", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b1) $display("FAIL miss_req got %b exp 1", sdr_req); else passes++;
    checks++; if (sdr_active !== 1'b1) $display("FAIL miss_active got %b exp 1", sdr_active); else passes++;
    checks++; if (sdr_addr !== BASE) $display("FAIL miss_addr got %h exp %h", sdr_addr, BASE); else passes++;
    wait_done("cached_rd0");
    checks++; if (ioctl_din !== 8'hEF) $display("FAIL rd0_din got %h exp EF", ioctl_din); else passes++;
    checks++; if (sdr_req !== 1'b0) $display("FAIL rd0_req got %b exp 0", sdr_req); else passes++;
    checks++; if (sdr_active !== 1'b1) $display("FAIL rd0_active_hold got %b exp 1", sdr_active); else passes++;
    tick();
    checks++; if (sdr_active !== 1'b0) $display("FAIL rd0_active_fall got %b exp 0", sdr_active); else passes++;
    c0 = req_cnt;
    do_read(25'd1);
    checks++; if (ioctl_din !== 8'hBE) $display("FAIL rd1_din got %h exp BE", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL rd1_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b0) $display("FAIL rd1_req got %b exp 0", sdr_req); else passes++;
    tick();
    checks++; if (req_cnt !== c0) $display("FAIL rd1_nreq got %0d exp %0d", req_cnt, c0); else passes++;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_b [0:7] = '{8'hEF, 8'hBE, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int c0, l0;
    ioctl_upload = 1'b0;
    tick();
    ioctl_upload = 1'b1;
    tick();
    c0 = req_cnt;
    l0 = addr_log.size();
    for (int i = 0; i < 8; i++) begin
      do_read(25'(i));
      wait_done("sweep");
      checks++; if (ioctl_din !== exp_b[i]) $display("FAIL sweep_byte%0d got %h exp %h", i, ioctl_din, exp_b[i]); else passes++;
    end
    tick();
    checks++; if (req_cnt - c0 !== 4) $display("FAIL sweep_nreq got %0d exp 4", req_cnt - c0); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (addr_log.size() <= l0 + k) $display("FAIL sweep_addr%0d got none exp %h", k, BASE + 24'(k));
      else if (addr_log[l0 + k] !== BASE + 24'(k)) $display("FAIL sweep_addr%0d got %h exp %h", k, addr_log[l0 + k], BASE + 24'(k));
      else passes++;
    end
  endtask

  task automatic test_range_index();
    do_read(25'(SIZE));
    checks++; if (ioctl_din !== 8'hFF) $display("FAIL oor_din got %h exp FF", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL oor_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b0) $display("FAIL oor_req got %b exp 0", sdr_req); else passes++;
    ioctl_index = 8'd0;
    tick();
    do_read(25'd2);
    checks++; if (ioctl_din !== 8'hFF) $display("FAIL idx_din got %h exp FF", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL idx_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b0) $display("FAIL idx_req got %b exp 0", sdr_req); else passes++;
    ioctl_index = IDX;
    tick(); tick();
  endtask

  task automatic test_abort();
    resp_en = 1'b0;
    tick();
    do_read(25'd6);
    checks++; if (sdr_req !== 1'b1) $display("FAIL abort_req0 got %b exp 1", sdr_req); else passes++;
    ioctl_upload = 1'b0;
    tick();
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL abort_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b1) $display("FAIL abort_req1 got %b exp 1", sdr_req); else passes++;
    tick();
    checks++; if (sdr_req !== 1'b1) $display("FAIL abort_req2 got %b exp 1", sdr_req); else passes++;
    sdr_dout = 16'hAAAA;
    sdr_rdy  = 1'b1;
    tick();
    sdr_rdy  = 1'b0;
    checks++; if (sdr_req !== 1'b0) $display("FAIL abort_req3 got %b exp 0", sdr_req); else passes++;
    checks++; if (ioctl_din !== 8'hFF) $display("FAIL abort_din got %h exp FF", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL abort_wait2 got %b exp 0", ioctl_wait); else passes++;
    resp_en = 1'b1;
    tick(); tick();
  endtask

  task automatic test_invalidate();
    ioctl_upload = 1'b1;
    tick(); tick();
    do_read(25'd0);
    wait_done("inval_first");
    checks++; if (ioctl_din !== 8'hEF) $display("FAIL inval_first got %h exp EF", ioctl_din); else passes++;
    ioctl_upload = 1'b0;
    tick();
    mem[0] = 16'h1234;
    ioctl_upload = 1'b1;
    tick();
    do_read(25'd0);
    checks++; if (ioctl_wait !== 1'b1) $display("FAIL inval_refetch got %b exp 1", ioctl_wait); else passes++;
    wait_done("inval_second");
    checks++; if (ioctl_din !== 8'h34) $display("FAIL inval_din got %h exp 34", ioctl_din); else passes++;
    tick(); tick();
  endtask

  task automatic test_reset_fetch_trigger();
    resp_en = 1'b0;
    tick();
    do_read(25'd4);
    checks++; if (sdr_req !== 1'b1) $display("FAIL rf_req_pre got %b exp 1", sdr_req); else passes++;
    reset = 1'b1;
    tick();
    checks++; if (ioctl_din !== 8'h00) $display("FAIL rf_din got %h exp 00", ioctl_din); else passes++;
    checks++; if (ioctl_wait !== 1'b0) $display("FAIL rf_wait got %b exp 0", ioctl_wait); else passes++;
    checks++; if (sdr_req !== 1'b0) $display("FAIL rf_req got %b exp 0", sdr_req); else passes++;
    checks++; if (sdr_active !== 1'b0) $display("FAIL rf_active got %b exp 0", sdr_active); else passes++;
    checks++; if (sdr_addr !== BASE) $display("FAIL rf_addr got %h exp %h", sdr_addr, BASE); else passes++;
    reset = 1'b0;
    tick();
    save_trigger = 1'b1;
    tick();
    save_trigger = 1'b0;
    checks++; if (ioctl_upload_req !== 1'b1) $display("FAIL trig_pulse got %b exp 1", ioctl_upload_req); else passes++;
    tick();
    checks++; if (ioctl_upload_req !== 1'b0) $display("FAIL trig_single got %b exp 0", ioctl_upload_req); else passes++;
  endtask

  initial begin
    reset        = 1'b1;
    save_trigger = 1'b0;
    ioctl_upload = 1'b0;
    ioctl_index  = 8'd0;
    ioctl_addr   = 25'd0;
    ioctl_rd     = 1'b0;
    mem[0] = 16'hBEEF;
    mem[1] = 16'h2211;
    mem[2] = 16'h4433;
    mem[3] = 16'h6655;
    mem[4] = 16'h0000;
    mem[5] = 16'h0000;
    mem[6] = 16'h0000;
    mem[7] = 16'h0000;
    test_reset();
    test_cached_read();
    test_sweep();
    test_range_index();
    test_abort();
    test_invalidate();
    test_reset_fetch_trigger();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
